// File: rtl/bcd_modcnt.sv
// -----------------------------------------------------------------------------
// bcd_modcnt
//
// Cascadable BCD modulo counter, for example the seconds, minutes or hours
// stage of a clock. It counts 0 .. MODULO-1 in packed BCD. It can also be
// preset through LOAD. It flags an illegal preset on ERR.
//
// Parameters
//   DIGITS   number of BCD digits (1..4)
//   MODULO   count modulus (2..10**DIGITS)
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous active-high reset (COUNT = 0, ERR = 0)
//   CEN       in   cascade count enable from the lower stage
//   INC       in   manual single step; never produces a carry out
//   UP        in   direction, 1 = up, 0 = down
//   LOAD      in   synchronous preset request; overrides CEN/INC
//   LOAD_VAL  in   BCD preset value, digit 0 in [3:0]
//   COUNT     out  registered BCD count, digit 0 in [3:0]
//   CA        out  combinational carry/borrow to the next stage
//   ERR       out  registered illegal-preset flag, held until the next LOAD
//
// Configuration
//   BCD_MODCNT_DOWN_EN  When this macro is defined, UP selects up or down
//                       counting. When it is not defined, UP is ignored and
//                       the block counts up only.
// -----------------------------------------------------------------------------
module bcd_modcnt #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned MODULO = 60
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  CEN,
   input  logic                  INC,
   input  logic                  UP,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VAL,
   output logic [4*DIGITS-1:0]   COUNT,
   output logic                  CA,
   output logic                  ERR
);

   localparam int unsigned W = 4 * DIGITS;

   // Binary-to-BCD conversion. It is used only at elaboration time to build
   // the terminal count.
   function automatic logic [W-1:0] to_bcd(input int unsigned v);
      logic [W-1:0] r;
      int unsigned  t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   // Largest legal count in BCD. When MODULO == 10**DIGITS this is all nines,
   // so the comparisons below never need a value wider than W bits.
   localparam logic [W-1:0] MAX_BCD = to_bcd(MODULO - 1);

   logic          up_eff;
   logic          step;
   logic          at_max;
   logic          at_zero;
   logic          terminal;
   logic          digits_ok;
   logic          load_legal;
   logic [W-1:0]  inc_val;
   logic [W-1:0]  dec_val;
   logic [W-1:0]  count_d;
   logic          err_d;
   logic          carry;
   logic          borrow;
   logic [3:0]    dig_inc;
   logic [3:0]    dig_dec;

   // -------------------------------------------------------------------------
   // Direction
   // -------------------------------------------------------------------------
`ifdef BCD_MODCNT_DOWN_EN
   assign up_eff = UP;
`else
   // The port is kept for pin compatibility. The up-only build ignores it.
   logic unused_up;
   assign unused_up = UP;
   assign up_eff    = 1'b1;
`endif

   // -------------------------------------------------------------------------
   // Step qualification and terminal detection
   // -------------------------------------------------------------------------
   // CEN and INC high together still give one step. LOAD masks both.
   assign step     = (CEN | INC) & ~LOAD;
   assign at_max   = (COUNT == MAX_BCD);
   assign at_zero  = (COUNT == '0);
   assign terminal = up_eff ? at_max : at_zero;

   // Only the cascade enable may ripple into the next stage. Manual INC
   // stepping must never disturb the higher digits of the clock.
   assign CA = CEN & ~LOAD & terminal;

   // -------------------------------------------------------------------------
   // BCD increment: each digit wraps 9 -> 0 and passes a carry upward.
   // -------------------------------------------------------------------------
   always_comb begin
      inc_val = '0;
      carry   = 1'b1;
      dig_inc = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig_inc = COUNT[4*i +: 4];
         if (carry) begin
            if (dig_inc == 4'd9) begin
               dig_inc = 4'd0;
            end else begin
               dig_inc = dig_inc + 4'd1;
               carry   = 1'b0;
            end
         end
         inc_val[4*i +: 4] = dig_inc;
      end
   end

   // -------------------------------------------------------------------------
   // BCD decrement: each digit wraps 0 -> 9 and passes a borrow upward.
   // -------------------------------------------------------------------------
   always_comb begin
      dec_val = '0;
      borrow  = 1'b1;
      dig_dec = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig_dec = COUNT[4*i +: 4];
         if (borrow) begin
            if (dig_dec == 4'd0) begin
               dig_dec = 4'd9;
            end else begin
               dig_dec = dig_dec - 4'd1;
               borrow  = 1'b0;
            end
         end
         dec_val[4*i +: 4] = dig_dec;
      end
   end

   // -------------------------------------------------------------------------
   // Preset validation
   // -------------------------------------------------------------------------
   // When every digit is 0..9, comparing the packed BCD vectors as unsigned
   // numbers orders them the same way as their decimal values.
   always_comb begin
      digits_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (LOAD_VAL[4*i +: 4] > 4'd9) begin
            digits_ok = 1'b0;
         end
      end
   end

   assign load_legal = digits_ok & (LOAD_VAL <= MAX_BCD);

   // -------------------------------------------------------------------------
   // Next state
   // -------------------------------------------------------------------------
   always_comb begin
      count_d = COUNT;
      err_d   = ERR;
      if (LOAD) begin
         // An illegal preset parks the counter at zero, so COUNT always
         // holds a legal value.
         count_d = load_legal ? LOAD_VAL : '0;
         err_d   = ~load_legal;
      end else if (step) begin
         if (up_eff) begin
            count_d = at_max ? '0 : inc_val;
         end else begin
            count_d = at_zero ? MAX_BCD : dec_val;
         end
      end
   end

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         COUNT <= '0;
         ERR   <= 1'b0;
      end else begin
         COUNT <= count_d;
         ERR   <= err_d;
      end
   end

endmodule

// File: tb/tb_bcd_modcnt.sv
// -----------------------------------------------------------------------------
// tb_bcd_modcnt
//
// Self-checking bench for bcd_modcnt. It uses two instances: the default
// 2-digit modulo-60 counter, and a 3-digit modulo-365 counter. The reference
// model keeps each count as a plain integer and does modular arithmetic on it.
// BCD appears only when the model value is converted for comparison.
// -----------------------------------------------------------------------------
module tb_bcd_modcnt;

`ifdef BCD_MODCNT_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;

   logic        a_cen, a_inc, a_up, a_load;
   logic [7:0]  a_lv, a_count;
   logic        a_ca, a_err;

   logic        b_cen, b_inc, b_up, b_load;
   logic [11:0] b_lv, b_count;
   logic        b_ca, b_err;

   int          n_checks = 0;
   int          n_fail   = 0;

   int          ma_cnt, mb_cnt;
   bit          ma_err, mb_err;
   bit          obs_ca_a, exp_ca_a, obs_ca_b, exp_ca_b;
   logic [11:0] exp12;

   always #5 clk = ~clk;

   bcd_modcnt #(.DIGITS(2), .MODULO(60)) dut_a (
      .clk(clk), .rst(rst), .CEN(a_cen), .INC(a_inc), .UP(a_up), .LOAD(a_load),
      .LOAD_VAL(a_lv), .COUNT(a_count), .CA(a_ca), .ERR(a_err)
   );

   bcd_modcnt #(.DIGITS(3), .MODULO(365)) dut_b (
      .clk(clk), .rst(rst), .CEN(b_cen), .INC(b_inc), .UP(b_up), .LOAD(b_load),
      .LOAD_VAL(b_lv), .COUNT(b_count), .CA(b_ca), .ERR(b_err)
   );

   // ---------------- reference model ----------------
   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[3:0]  = 4'(v % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return r;
   endfunction

   // Decimal value of a BCD word, or -1 if any digit is not a decimal digit.
   function automatic int bcd_val(input logic [11:0] lv, input int nd);
      int v = 0;
      for (int i = nd - 1; i >= 0; i--) begin
         if (lv[4*i +: 4] > 4'd9) return -1;
         v = v * 10 + int'(lv[4*i +: 4]);
      end
      return v;
   endfunction

   function automatic int next_val(input int cur, input bit cen, input bit inc, input bit up,
                                   input bit load, input int lval, input int modulo);
      bit upe = DOWN_EN ? up : 1'b1;
      if (load) return (lval >= 0 && lval < modulo) ? lval : 0;
      if (cen || inc) return upe ? (cur + 1) % modulo : (cur + modulo - 1) % modulo;
      return cur;
   endfunction

   function automatic bit model_ca(input int cur, input bit cen, input bit load, input bit up,
                                   input int modulo);
      bit upe = DOWN_EN ? up : 1'b1;
      return cen && !load && (upe ? (cur == modulo - 1) : (cur == 0));
   endfunction

   // One clock cycle on instance A. CA is sampled mid-cycle and the model is
   // advanced. Inputs are applied 1 time unit after a rising edge.
   task automatic cycle_a(input bit cen, input bit inc, input bit up, input bit load,
                          input logic [7:0] lv);
      int lval;
      a_cen = cen; a_inc = inc; a_up = up; a_load = load; a_lv = lv;
      #1;
      obs_ca_a = a_ca;
      exp_ca_a = model_ca(ma_cnt, cen, load, up, 60);
      lval = bcd_val({4'h0, lv}, 2);
      if (load) ma_err = !(lval >= 0 && lval < 60);
      ma_cnt = next_val(ma_cnt, cen, inc, up, load, lval, 60);
      @(posedge clk);
      #1;
   endtask

   task automatic cycle_b(input bit cen, input bit inc, input bit up, input bit load,
                          input logic [11:0] lv);
      int lval;
      b_cen = cen; b_inc = inc; b_up = up; b_load = load; b_lv = lv;
      #1;
      obs_ca_b = b_ca;
      exp_ca_b = model_ca(mb_cnt, cen, load, up, 365);
      lval = bcd_val(lv, 3);
      if (load) mb_err = !(lval >= 0 && lval < 365);
      mb_cnt = next_val(mb_cnt, cen, inc, up, load, lval, 365);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_cen = 0; a_inc = 0; a_up = 1; a_load = 0; a_lv = '0;
      b_cen = 0; b_inc = 0; b_up = 1; b_load = 0; b_lv = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_checks++; if (a_count !== 8'h00) begin n_fail++;
         $display("FAIL reset_count_a: got %h expected 00", a_count); end
      n_checks++; if (a_err !== 1'b0) begin n_fail++;
         $display("FAIL reset_err_a: got %b expected 0", a_err); end
      n_checks++; if (b_count !== 12'h000) begin n_fail++;
         $display("FAIL reset_count_b: got %h expected 000", b_count); end
      // CA is driven from COUNT = 0 while reset is asserted.
      a_cen = 1; a_up = 0; #1;
      n_checks++; if (a_ca !== DOWN_EN) begin n_fail++;
         $display("FAIL reset_ca_down: got %b expected %b", a_ca, DOWN_EN); end
      a_up = 1; #1;
      n_checks++; if (a_ca !== 1'b0) begin n_fail++;
         $display("FAIL reset_ca_up: got %b expected 0", a_ca); end
      // A LOAD presented across an edge during reset must be discarded.
      a_load = 1; a_lv = 8'h45; b_load = 1; b_lv = 12'h123;
      @(posedge clk); #1;
      n_checks++; if (a_count !== 8'h00 || b_count !== 12'h000) begin n_fail++;
         $display("FAIL reset_load_discard: got %h/%h expected 00/000", a_count, b_count); end
      idle_inputs();
      rst = 0;
      ma_cnt = 0; ma_err = 0; mb_cnt = 0; mb_err = 0;
      cycle_a(1, 0, 1, 0, 8'h00);
      n_checks++; if (a_count !== 8'h01) begin n_fail++;
         $display("FAIL reset_first_edge: got %h expected 01", a_count); end
   endtask

   task automatic test_up_wrap();
      logic [7:0] e8;
      cycle_a(0, 0, 1, 1, 8'h00);
      for (int i = 0; i < 59; i++) begin
         cycle_a(1, 0, 1, 0, 8'h00);
         exp12 = to_bcd(i + 1);
         e8 = exp12[7:0];
         n_checks++; if (obs_ca_a !== 1'b0 || a_count !== e8) begin n_fail++;
            $display("FAIL up_sweep step %0d: got ca=%b count=%h expected ca=0 count=%h",
                     i, obs_ca_a, a_count, e8); end
      end
      cycle_a(1, 0, 1, 0, 8'h00);
      n_checks++; if (obs_ca_a !== 1'b1 || a_count !== 8'h00) begin n_fail++;
         $display("FAIL up_wrap: got ca=%b count=%h expected ca=1 count=00",
                  obs_ca_a, a_count); end
   endtask

   task automatic test_inc_no_cascade();
      cycle_a(0, 0, 1, 1, 8'h59);
      cycle_a(0, 1, 1, 0, 8'h00);
      n_checks++; if (obs_ca_a !== 1'b0 || a_count !== 8'h00) begin n_fail++;
         $display("FAIL inc_wrap: got ca=%b count=%h expected ca=0 count=00",
                  obs_ca_a, a_count); end
      // CEN and INC together produce a single step.
      cycle_a(0, 0, 1, 1, 8'h10);
      cycle_a(1, 1, 1, 0, 8'h00);
      n_checks++; if (a_count !== 8'h11) begin n_fail++;
         $display("FAIL cen_inc_single: got %h expected 11", a_count); end
   endtask

   task automatic test_down();
`ifdef BCD_MODCNT_DOWN_EN
      cycle_a(0, 0, 0, 1, 8'h00);
      cycle_a(1, 0, 0, 0, 8'h00);
      n_checks++; if (obs_ca_a !== 1'b1 || a_count !== 8'h59) begin n_fail++;
         $display("FAIL down_wrap: got ca=%b count=%h expected ca=1 count=59",
                  obs_ca_a, a_count); end
      cycle_a(1, 0, 0, 0, 8'h00);
      n_checks++; if (obs_ca_a !== 1'b0 || a_count !== 8'h58) begin n_fail++;
         $display("FAIL down_step: got ca=%b count=%h expected ca=0 count=58",
                  obs_ca_a, a_count); end
      cycle_a(0, 0, 0, 1, 8'h10);
      cycle_a(1, 0, 0, 0, 8'h00);
      n_checks++; if (a_count !== 8'h09) begin n_fail++;
         $display("FAIL down_borrow: got %h expected 09", a_count); end
`else
      // In the up-only build, UP = 0 must still count up.
      cycle_a(0, 0, 0, 1, 8'h00);
      cycle_a(1, 0, 0, 0, 8'h00);
      n_checks++; if (obs_ca_a !== 1'b0 || a_count !== 8'h01) begin n_fail++;
         $display("FAIL up_only_ignore_up: got ca=%b count=%h expected ca=0 count=01",
                  obs_ca_a, a_count); end
      cycle_a(0, 0, 0, 1, 8'h59);
      cycle_a(1, 0, 0, 0, 8'h00);
      n_checks++; if (obs_ca_a !== 1'b1 || a_count !== 8'h00) begin n_fail++;
         $display("FAIL up_only_wrap: got ca=%b count=%h expected ca=1 count=00",
                  obs_ca_a, a_count); end
`endif
   endtask

   task automatic test_load();
      cycle_a(0, 0, 1, 1, 8'h59);
      cycle_a(1, 0, 1, 1, 8'h45);
      n_checks++; if (obs_ca_a !== 1'b0 || a_count !== 8'h45 || a_err !== 1'b0) begin n_fail++;
         $display("FAIL load_45: got ca=%b count=%h err=%b expected 0/45/0",
                  obs_ca_a, a_count, a_err); end
      cycle_a(0, 0, 1, 1, 8'h60);
      n_checks++; if (a_count !== 8'h00 || a_err !== 1'b1) begin n_fail++;
         $display("FAIL load_60: got count=%h err=%b expected 00/1", a_count, a_err); end
      cycle_a(0, 0, 1, 1, 8'h3A);
      n_checks++; if (a_count !== 8'h00 || a_err !== 1'b1) begin n_fail++;
         $display("FAIL load_3A: got count=%h err=%b expected 00/1", a_count, a_err); end
      cycle_a(1, 0, 1, 0, 8'h00);
      n_checks++; if (a_count !== 8'h01 || a_err !== 1'b1) begin n_fail++;
         $display("FAIL err_hold: got count=%h err=%b expected 01/1", a_count, a_err); end
      cycle_a(0, 0, 1, 1, 8'h12);
      n_checks++; if (a_count !== 8'h12 || a_err !== 1'b0) begin n_fail++;
         $display("FAIL load_12: got count=%h err=%b expected 12/0", a_count, a_err); end
   endtask

   task automatic test_async_reset();
      cycle_a(0, 0, 1, 1, 8'hA0);
      for (int i = 0; i < 37; i++) cycle_a(1, 0, 1, 0, 8'h00);
      n_checks++; if (a_count !== 8'h37 || a_err !== 1'b1) begin n_fail++;
         $display("FAIL pre_reset: got count=%h err=%b expected 37/1", a_count, a_err); end
      idle_inputs();
      #2 rst = 1;
      #1;
      n_checks++; if (a_count !== 8'h00 || a_err !== 1'b0) begin n_fail++;
         $display("FAIL async_reset: got count=%h err=%b expected 00/0", a_count, a_err); end
      #2 rst = 0;
      ma_cnt = 0; ma_err = 0; mb_cnt = 0; mb_err = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_mod365();
      cycle_b(0, 0, 1, 1, 12'h364);
      cycle_b(1, 0, 1, 0, 12'h000);
      n_checks++; if (obs_ca_b !== 1'b1 || b_count !== 12'h000) begin n_fail++;
         $display("FAIL m365_wrap: got ca=%b count=%h expected ca=1 count=000",
                  obs_ca_b, b_count); end
      cycle_b(0, 0, 1, 1, 12'h099);
      cycle_b(1, 0, 1, 0, 12'h000);
      n_checks++; if (obs_ca_b !== 1'b0 || b_count !== 12'h100) begin n_fail++;
         $display("FAIL m365_099: got ca=%b count=%h expected ca=0 count=100",
                  obs_ca_b, b_count); end
      cycle_b(0, 0, 1, 1, 12'h199);
      cycle_b(1, 0, 1, 0, 12'h000);
      n_checks++; if (b_count !== 12'h200) begin n_fail++;
         $display("FAIL m365_199: got %h expected 200", b_count); end
      cycle_b(0, 0, 1, 1, 12'h365);
      n_checks++; if (b_count !== 12'h000 || b_err !== 1'b1) begin n_fail++;
         $display("FAIL m365_load_365: got count=%h err=%b expected 000/1", b_count, b_err); end
   endtask

   task automatic test_random();
      logic [7:0]  e8;
      logic [7:0]  lv8;
      logic [11:0] lv12;
      for (int i = 0; i < 400; i++) begin
         lv8 = 8'($urandom);
         cycle_a(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(7) == 0), lv8);
         exp12 = to_bcd(ma_cnt);
         e8 = exp12[7:0];
         n_checks++;
         if (obs_ca_a !== exp_ca_a || a_count !== e8 || a_err !== ma_err) begin n_fail++;
            $display("FAIL rand_a cycle %0d: got ca=%b count=%h err=%b expected %b/%h/%b",
                     i, obs_ca_a, a_count, a_err, exp_ca_a, e8, ma_err); end
      end
      for (int i = 0; i < 300; i++) begin
         lv12 = 12'($urandom);
         cycle_b(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(7) == 0), lv12);
         exp12 = to_bcd(mb_cnt);
         n_checks++;
         if (obs_ca_b !== exp_ca_b || b_count !== exp12 || b_err !== mb_err) begin n_fail++;
            $display("FAIL rand_b cycle %0d: got ca=%b count=%h err=%b expected %b/%h/%b",
                     i, obs_ca_b, b_count, b_err, exp_ca_b, exp12, mb_err); end
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      ma_cnt = 0; ma_err = 0; mb_cnt = 0; mb_err = 0;
      @(posedge clk); #1;
      test_reset();
      test_up_wrap();
      test_inc_no_cascade();
      test_down();
      test_load();
      test_async_reset();
      test_mod365();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
